// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : IDLE (nothing outstanding) / BUSY (one transaction outstanding)
//   arb_owner_t : which requester owns the outstanding transaction
//   STARVE_W    : width of the fetch starvation counter
//   dword_align : clears the byte offset within a 64-bit doubleword
package mem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  function automatic logic [63:0] dword_align(input logic [63:0] addr);
    return addr & ~64'h7;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
// Saturating count of consecutive cycles in which fetch asked for the memory
// and was refused. Once the count reaches STARVE_MAX, at_max tells the
// arbiter to let fetch win over data.
// Ports:
//   clk, rst : clock (rising edge) and asynchronous active-low reset
//   inc      : fetch was eligible but not granted this cycle
//   clr      : fetch was granted, or is not requesting
//   hold     : freeze the count (a transaction is outstanding)
//   at_max   : count equals STARVE_MAX
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // hold beats clr beats inc; increments stop at MAX_V
  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-ported unified memory between instruction fetch (IF) and
// the load/store path (D). Data wins by default; after STARVE_MAX consecutive
// refused fetch cycles fetch wins instead. Exactly one transaction is in
// flight at a time. A redirect (flush) kills an outstanding fetch so that its
// response is swallowed.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   if_req/if_addr           : fetch read request, word address
//   if_gnt/if_rvalid/if_rdata: fetch accept, response valid, instruction word
//   if_wait                  : fetch must stall (feeds StallF)
//   flush                    : branch redirect, kills outstanding fetch
//   d_req/d_we/d_addr/d_wdata/d_be : data request and store payload
//   d_gnt/d_rvalid/d_rdata   : data accept, response valid, load doubleword
//   m_req/m_we/m_addr/m_wdata/m_be : request to the memory macro
//   m_gnt/m_rvalid/m_rdata   : memory accept, in-order response, read data
// Optional build macro MEM_ARB_PERF_EN adds perf_if_wait_cnt, perf_d_gnt_cnt
// and perf_kill_cnt wrapping event counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_wait,
  input  logic        flush,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_be,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [63:0] m_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_wait_cnt,
  output logic [31:0] perf_d_gnt_cnt,
  output logic [15:0] perf_kill_cnt
`endif
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic       kill_q, kill_d;
  logic       hi_q, hi_d;

  logic idle, busy;
  logic if_win, d_win, if_take, d_take;
  logic at_max;

  assign idle = (state_q == IDLE);
  assign busy = (state_q == BUSY);

  // Winner selection only happens in IDLE. A flushed fetch is not eligible,
  // so data (or nobody) gets the slot that cycle.
  assign if_win  = idle & if_req & ~flush & (~d_req | at_max);
  assign d_win   = idle & d_req & ~if_win;
  assign if_take = if_win & m_gnt;
  assign d_take  = d_win & m_gnt;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (idle & if_req & ~flush & ~if_take),
    .clr   (idle & (if_take | ~if_req)),
    .hold  (busy),
    .at_max(at_max)
  );

  // Next-state: grant moves to BUSY and records owner and word half; in BUSY
  // a flush marks an owned fetch as killed and the response returns to IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    kill_d  = kill_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (if_take || d_take) begin
          state_d = BUSY;
          owner_d = if_take ? OWN_IF : OWN_D;
          kill_d  = 1'b0;
          if (if_take) begin
            hi_d = if_addr[2];
          end
        end
      end
      BUSY: begin
        if (flush && (owner_q == OWN_IF)) begin
          kill_d = 1'b1;
        end
        if (m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      kill_q  <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      hi_q    <= hi_d;
    end
  end

  // Outputs are combinational from the inputs, so they are forced to zero
  // while rst is low to keep the memory and pipeline quiet during reset.
  always_comb begin
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_be      = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    if_wait   = 1'b0;
    if (rst) begin
      m_req = if_win | d_win;
      if (if_win) begin
        m_addr = dword_align(if_addr);
        m_be   = 8'hFF;
      end else if (d_win) begin
        m_addr  = dword_align(d_addr);
        m_we    = d_we;
        m_wdata = d_wdata;
        m_be    = d_we ? d_be : 8'hFF;
      end
      if_gnt    = if_take;
      d_gnt     = d_take;
      // A flush in the response cycle drops the fetch response as well.
      if_rvalid = busy & m_rvalid & (owner_q == OWN_IF) & ~kill_q & ~flush;
      d_rvalid  = busy & m_rvalid & (owner_q == OWN_D);
      if_rdata  = hi_q ? m_rdata[63:32] : m_rdata[31:0];
      d_rdata   = m_rdata;
      if_wait   = (if_req & ~if_take) |
                  (busy & (owner_q == OWN_IF) & ~kill_q & ~m_rvalid);
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] dgnt_cnt_q, dgnt_cnt_d;
  logic [15:0] kill_cnt_q, kill_cnt_d;
  logic        kill_evt;

  // A fetch response is swallowed if it was killed earlier or is flushed now.
  assign kill_evt = busy & m_rvalid & (owner_q == OWN_IF) & (kill_q | flush);

  always_comb begin
    wait_cnt_d = wait_cnt_q + (if_wait ? 32'd1 : 32'd0);
    dgnt_cnt_d = dgnt_cnt_q + (d_gnt ? 32'd1 : 32'd0);
    kill_cnt_d = kill_cnt_q + (kill_evt ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      dgnt_cnt_q <= '0;
      kill_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      dgnt_cnt_q <= dgnt_cnt_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign perf_if_wait_cnt = wait_cnt_q;
  assign perf_d_gnt_cnt   = dgnt_cnt_q;
  assign perf_kill_cnt    = kill_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter with directed scenarios followed by constrained
// random traffic, and compares every cycle against a transaction-level model
// of the arbiter kept in this file.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_wait;
  logic        flush;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic        m_gnt;
  logic        m_rvalid;
  logic [63:0] m_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait_cnt;
  logic [31:0] perf_d_gnt_cnt;
  logic [15:0] perf_kill_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Model state: one outstanding transaction at most
  bit mBusy, mOwnerIf, mKilled, mHi;
  int mDenied;
  int mKills, mDGrants, mWaitCycles;

  // Model predictions for the current cycle
  logic        eMReq, eMWe, eIfGnt, eDGnt, eIfRvalid, eDRvalid, eIfWait;
  logic [63:0] eMAddr, eMWdata, eDRdata;
  logic [7:0]  eMBe;
  logic [31:0] eIfRdata;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_wait(if_wait),
    .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_wait_cnt(perf_if_wait_cnt),
    .perf_d_gnt_cnt(perf_d_gnt_cnt),
    .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [63:0] ifAddr, input logic fl,
                               input logic dReq, input logic dWe, input logic [63:0] dAddr,
                               input logic [63:0] dWdata, input logic [7:0] dBe,
                               input logic mGnt, input logic mRvalid, input logic [63:0] mRdata);
    if_req   = ifReq;
    if_addr  = ifAddr;
    flush    = fl;
    d_req    = dReq;
    d_we     = dWe;
    d_addr   = dAddr;
    d_wdata  = dWdata;
    d_be     = dBe;
    m_gnt    = mGnt;
    m_rvalid = mRvalid;
    m_rdata  = mRdata;
  endtask

  // Outputs expected from the arbitration rules, given model state and inputs
  task automatic predict();
    logic fetchOk, ifFirst, dFirst;
    logic [63:0] pick;
    eMReq = 0; eMWe = 0; eMAddr = 0; eMWdata = 0; eMBe = 0;
    eIfGnt = 0; eDGnt = 0; eIfRvalid = 0; eDRvalid = 0; eIfWait = 0;
    eIfRdata = 32'(m_rdata >> (mHi ? 32 : 0));
    eDRdata = m_rdata;
    if (!rst) begin
      eIfRdata = 0;
      eDRdata = 0;
    end else if (!mBusy) begin
      fetchOk = if_req && !flush;
      ifFirst = fetchOk && (!d_req || (mDenied >= STARVE_MAX));
      dFirst  = d_req && !ifFirst;
      eMReq   = ifFirst || dFirst;
      pick    = ifFirst ? if_addr : d_addr;
      if (eMReq) eMAddr = pick - (pick % 8);
      eMWe    = dFirst && d_we;
      eMBe    = !eMReq ? 8'h00 : (eMWe ? d_be : 8'hFF);
      eMWdata = d_wdata;
      eIfGnt  = ifFirst && m_gnt;
      eDGnt   = dFirst && m_gnt;
      eIfWait = if_req && !eIfGnt;
    end else begin
      eIfRvalid = m_rvalid && mOwnerIf && !mKilled && !flush;
      eDRvalid  = m_rvalid && !mOwnerIf;
      eIfWait   = if_req || (mOwnerIf && !mKilled && !m_rvalid);
    end
  endtask

  // Compares every meaningful output against the model at the falling edge
  task automatic checkOutput();
    @(negedge clk);
    predict();
    checkField("m_req", m_req, eMReq);
    checkField("if_gnt", if_gnt, eIfGnt);
    checkField("d_gnt", d_gnt, eDGnt);
    checkField("if_rvalid", if_rvalid, eIfRvalid);
    checkField("d_rvalid", d_rvalid, eDRvalid);
    checkField("if_wait", if_wait, eIfWait);
    if (!rst) begin
      checkField("rst_m_we", m_we, 0);
      checkField("rst_m_addr", m_addr, 0);
      checkField("rst_m_wdata", m_wdata, 0);
      checkField("rst_m_be", m_be, 0);
      checkField("rst_if_rdata", if_rdata, 0);
      checkField("rst_d_rdata", d_rdata, 0);
    end else if (eMReq) begin
      checkField("m_addr", m_addr, eMAddr);
      checkField("m_we", m_we, eMWe);
      checkField("m_be", m_be, eMBe);
      if (eMWe) checkField("m_wdata", m_wdata, eMWdata);
    end
    if (eIfRvalid) checkField("if_rdata", if_rdata, eIfRdata);
    if (eDRvalid) checkField("d_rdata", d_rdata, eDRdata);
  endtask

  // Moves the model to the state after the coming rising edge, then waits it
  task automatic advanceCycle();
    if (!rst) begin
      mBusy = 0; mOwnerIf = 0; mKilled = 0; mHi = 0; mDenied = 0;
      mKills = 0; mDGrants = 0; mWaitCycles = 0;
    end else begin
      if (eDGnt) mDGrants++;
      if (eIfWait) mWaitCycles++;
      if (!mBusy) begin
        if (eIfGnt) begin
          mBusy = 1; mOwnerIf = 1; mKilled = 0; mHi = if_addr[2];
        end else if (eDGnt) begin
          mBusy = 1; mOwnerIf = 0; mKilled = 0;
        end
        if (eIfGnt || !if_req) mDenied = 0;
        else if (!flush) mDenied++;
      end else begin
        if (m_rvalid) begin
          if (mOwnerIf && (mKilled || flush)) mKills++;
          mBusy = 0;
        end
        if (flush && mOwnerIf) mKilled = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, mBusy, {$urandom, $urandom});
    checkOutput();
    advanceCycle();
  endtask

  // Fetch granted, then its response swallowed: variant 0 flushes one cycle
  // before the response, variant 1 flushes in the response cycle
  task automatic killFetch(input int variant);
    applyStimulus(1, 64'h8004, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    advanceCycle();
    if (variant == 0) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234);
    end else begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h1234);
    end
    checkOutput();
    checkField("kill_if_rvalid", if_rvalid, 0);
    advanceCycle();
  endtask

  initial begin
    string seq;
    int budget;
    logic ifPend, dPend;
    logic nIfReq, nDReq, nDWe;
    logic [63:0] nIfAddr, nDAddr, nDWdata;
    logic [7:0] nDBe;

    // Reset with both requesters active: everything must stay quiet
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 64'h40, 0, 1, 1, 64'h80, 64'hFF, 8'hFF, 1, 0, 64'hDEAD);
      checkOutput();
      checkField("reset_m_req", m_req, 0);
      checkField("reset_d_gnt", d_gnt, 0);
      checkField("reset_m_be", m_be, 0);
      advanceCycle();
    end
    rst = 1;

    // Lone fetch from the upper word of a doubleword
    applyStimulus(1, 64'h1004, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    checkField("lone_if_gnt", if_gnt, 1);
    checkField("lone_m_addr", m_addr, 64'h1000);
    checkField("lone_m_be", m_be, 8'hFF);
    checkField("lone_if_wait", if_wait, 0);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hAAAABBBB_CCCCDDDD);
    checkOutput();
    checkField("lone_if_rvalid", if_rvalid, 1);
    checkField("lone_if_rdata", if_rdata, 32'hAAAABBBB);
    advanceCycle();

    // Continuous contention with a one-cycle memory
    seq = "";
    budget = 0;
    while (seq.len() < 10 && budget < 100) begin
      applyStimulus(1, 64'h2000, 0, 1, 0, 64'h3000, 0, 0, 1, mBusy, {$urandom, $urandom});
      checkOutput();
      if (if_gnt) seq = {seq, "I"};
      else if (d_gnt) seq = {seq, "D"};
      advanceCycle();
      budget++;
    end
    vectors++;
    if (seq != "DDDDIDDDDI") begin
      miscompares++;
      $display("[TB] FAIL contention_order: got %s, expected DDDDIDDDDI", seq);
    end
    idleCycle();
    idleCycle();

    // Flush one cycle after a fetch grant; data waits for the next IDLE cycle
    applyStimulus(1, 64'h1008, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    checkField("flush_if_gnt", if_gnt, 1);
    advanceCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    advanceCycle();
    applyStimulus(0, 0, 0, 1, 0, 64'h4000, 0, 0, 1, 1, 64'h5555);
    checkOutput();
    checkField("flush_if_rvalid", if_rvalid, 0);
    checkField("flush_if_wait", if_wait, 0);
    checkField("flush_busy_d_gnt", d_gnt, 0);
    advanceCycle();
    applyStimulus(0, 0, 0, 1, 0, 64'h4000, 0, 0, 1, 0, 0);
    checkOutput();
    checkField("flush_d_gnt", d_gnt, 1);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0123456789ABCDEF);
    checkOutput();
    checkField("flush_d_rvalid", d_rvalid, 1);
    checkField("flush_d_rdata", d_rdata, 64'h0123456789ABCDEF);
    advanceCycle();

    // Flush arriving together with the fetch response
    applyStimulus(1, 64'h100C, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    advanceCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h7777);
    checkOutput();
    checkField("simul_flush_if_rvalid", if_rvalid, 0);
    advanceCycle();

    // Store while fetch waits
    applyStimulus(1, 64'h5000, 0, 1, 1, 64'h6008, 64'h11223344, 8'h0F, 1, 0, 0);
    checkOutput();
    checkField("store_d_gnt", d_gnt, 1);
    checkField("store_m_we", m_we, 1);
    checkField("store_m_be", m_be, 8'h0F);
    checkField("store_m_wdata", m_wdata, 64'h11223344);
    checkField("store_if_wait", if_wait, 1);
    advanceCycle();
    applyStimulus(1, 64'h5000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    checkField("store_busy_if_wait", if_wait, 1);
    advanceCycle();
    applyStimulus(1, 64'h5000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput();
    checkField("store_d_rvalid", d_rvalid, 1);
    checkField("store_rsp_if_wait", if_wait, 1);
    advanceCycle();
    applyStimulus(1, 64'h5000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    checkField("store_then_if_gnt", if_gnt, 1);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h99998888_77776666);
    checkOutput();
    checkField("store_then_if_rdata", if_rdata, 32'h77776666);
    advanceCycle();

    // Reset while a fetch is outstanding, then a stray response
    applyStimulus(1, 64'h7000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput();
    advanceCycle();
    rst = 0;
    applyStimulus(1, 64'h7000, 0, 1, 0, 64'h40, 0, 0, 1, 0, 0);
    checkOutput();
    checkField("midrst_m_req", m_req, 0);
    checkField("midrst_if_wait", if_wait, 0);
    advanceCycle();
    rst = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hABCD);
    checkOutput();
    checkField("stray_if_rvalid", if_rvalid, 0);
    checkField("stray_d_rvalid", d_rvalid, 0);
    advanceCycle();

    // Three killed fetches
    killFetch(0);
    killFetch(1);
    killFetch(0);
`ifdef MEM_ARB_PERF_EN
    checkField("perf_kill_three", perf_kill_cnt, 3);
`endif

    // Random traffic honouring hold-until-grant
    ifPend = 0;
    dPend = 0;
    nIfReq = 0; nIfAddr = 0; nDReq = 0; nDWe = 0; nDAddr = 0; nDWdata = 0; nDBe = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ifPend) begin
        nIfReq  = ($urandom_range(0, 99) < 55);
        nIfAddr = {$urandom, $urandom} & ~64'h3;
      end
      if (!dPend) begin
        nDReq   = ($urandom_range(0, 99) < 45);
        nDWe    = $urandom_range(0, 1) == 1;
        nDAddr  = {$urandom, $urandom};
        nDWdata = {$urandom, $urandom};
        nDBe    = 8'($urandom);
      end
      rst = ($urandom_range(0, 399) != 0);
      applyStimulus(nIfReq, nIfAddr, $urandom_range(0, 99) < 15, nDReq, nDWe, nDAddr,
                    nDWdata, nDBe, $urandom_range(0, 99) < 75,
                    mBusy && ($urandom_range(0, 99) < 45), {$urandom, $urandom});
      checkOutput();
      ifPend = if_req && !eIfGnt;
      dPend  = d_req && !eDGnt;
      advanceCycle();
    end
    rst = 1;
`ifdef MEM_ARB_PERF_EN
    checkField("perf_if_wait_cnt", perf_if_wait_cnt, 32'(mWaitCycles));
    checkField("perf_d_gnt_cnt", perf_d_gnt_cnt, 32'(mDGrants));
    checkField("perf_kill_cnt", perf_kill_cnt, 16'(mKills));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
